ws2812_rx: RTL
==============

WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 SHALL have parameter NUM_PIX, default 6, the maximum number of 24-bit pixels accepted per frame.
REQ-002 SHALL have parameter LATCH_CYC, default 1200, the continuous low time in clk cycles that ends a frame.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port din, input, 1 bit: asynchronous single-wire NRZ LED data line.
REQ-006 SHALL have port pixel, output, 24 bits: last decoded pixel, first received bit in bit 23.
REQ-007 SHALL have port pixel_idx, output, 3 bits: index of pixel within the frame, 0 to NUM_PIX-1.
REQ-008 SHALL have port pixel_valid, output, 1 bit: one-cycle strobe qualifying pixel and pixel_idx.
REQ-009 SHALL have port frame_done, output, 1 bit: one-cycle strobe at a clean frame latch.
REQ-010 SHALL have port err, output, 1 bit: one-cycle strobe on any protocol violation.

Function
REQ-011 SHALL pass din through a 2-flop synchronizer; all decode uses the synchronized value ds and its registered copy ds_q.
REQ-012 SHALL use states IDLE, HIGH, LOW and RECOVER.
REQ-013 SHALL, in IDLE, go to HIGH on the first cycle ds=1 with the width counter cleared to 1.
REQ-014 SHALL, in HIGH, increment the width counter each cycle ds=1, saturating at 63.
REQ-015 SHALL, on a HIGH-state falling edge (ds=0, ds_q=1), classify the pulse by width: below 3 is a glitch (err, go to RECOVER); 3..12 is bit 0; 13..30 is bit 1.
REQ-016 SHALL, on a valid bit, shift it into the 24-bit shift register LSB-first-in (first bit ends in pixel[23]), increment the 5-bit bit counter, and enter LOW.
REQ-017 SHALL flag err and enter RECOVER as soon as the HIGH width counter exceeds 30, without waiting for the falling edge.
REQ-018 SHALL, on the 24th bit, load pixel, drive pixel_idx with the current pixel count, pulse pixel_valid in the next cycle, clear the bit counter and increment the pixel count.
REQ-019 SHALL, in LOW, count low cycles; ds=1 returns to HIGH with the width counter set to 1.
REQ-020 SHALL, when the low counter reaches LATCH_CYC in LOW with bit counter 0, pulse frame_done, clear the pixel count and go to IDLE.
REQ-021 SHALL, when the low counter reaches LATCH_CYC in LOW with bit counter not 0, pulse err instead of frame_done, discard the partial pixel, clear both counters and go to IDLE.
REQ-022 SHALL treat bits arriving after NUM_PIX pixels as follows: decode them but produce no pixel_valid, and pulse err exactly once per frame on the first such bit.
REQ-023 SHALL, in RECOVER, wait for LATCH_CYC consecutive low cycles, then clear all counters and go to IDLE; any ds=1 restarts the wait.
REQ-024 SHALL never assert pixel_valid, frame_done and err in the same cycle, except that an overflow err may coincide with no other strobe.

Reset
REQ-025 SHALL, while rst=1, force state to RECOVER, clear all counters and the synchronizer, and hold pixel=0, pixel_idx=0, pixel_valid=0, frame_done=0 and err=0.
REQ-026 SHALL, after rst deasserts, require a full LATCH_CYC low period before accepting bits, so a reset mid-frame never yields a partial pixel.

Structure
REQ-027 SHALL take the state enum, the width thresholds (3/13/30), the width-counter saturation value 63 and the LATCH_CYC default from shared package ws2812_pkg, which the transmitter also uses.
REQ-028 SHALL instantiate one sub-module, pulse_timer: a resettable saturating up-counter with a compare-reached output, used once for high width and once for low time.
REQ-029 SHALL be implementable in 120-400 lines of RTL.

Verification
REQ-030 SHALL check: reset, 1200 low cycles, then 24 bits of 0xA5C30F (1 = 18 high/7 low, 0 = 8 high/17 low), then 1200 low -> one pixel_valid with pixel=0xA5C30F and pixel_idx=0, then frame_done.
REQ-031 SHALL check: 6 pixels 0x000001..0x000006 back-to-back followed by a latch -> six pixel_valid strobes with idx 0..5 and matching data, then one frame_done.
REQ-032 SHALL check: 7 pixels in one frame -> six pixel_valid, one err on the first bit of pixel 7, and frame_done after the latch.
REQ-033 SHALL check: a 2-cycle high glitch mid-pixel -> err, no pixel_valid until 1200 low cycles pass and a fresh frame of 0x123456 decodes correctly.
REQ-034 SHALL check: a 35-cycle high pulse -> err at width 31, then RECOVER; also 10 bits then a 1200-cycle low -> err, no frame_done, no pixel_valid.
REQ-035 SHALL check: rst asserted after 12 bits -> all outputs 0, and the next frame's first pixel decodes with idx 0.

Source files
------------

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: constants and types shared by the WS2812 receiver and transmitter.
// Contents: FSM state enum, high-pulse width thresholds, width-counter
// saturation value and the default frame latch time in clk cycles.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HIGH    = 2'd1,
    LOW     = 2'd2,
    RECOVER = 2'd3
  } ws_state_e;

  localparam int unsigned WCNT_W        = 6;    // width counter bits
  localparam int unsigned WID_MIN       = 3;    // shorter high pulse is a glitch
  localparam int unsigned WID_ONE       = 13;   // first width decoded as a 1
  localparam int unsigned WID_MAX       = 30;   // longest legal high pulse
  localparam int unsigned WID_SAT       = 63;   // width counter saturation
  localparam int unsigned LATCH_CYC_DEF = 1200; // low time that ends a frame

endpackage

// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if: LED data line plus decoded pixel/status strobes.
//   din         : raw single-wire NRZ data (asynchronous)
//   pixel       : last decoded 24-bit pixel, first received bit in bit 23
//   pixel_idx   : index of pixel within the frame
//   pixel_valid : one-cycle strobe qualifying pixel/pixel_idx
//   frame_done  : one-cycle strobe at a clean frame latch
//   err         : one-cycle strobe on a protocol violation
// master = line driver / consumer side, slave = the decoder.
interface ws2812_rx_if;
  logic        din;
  logic [23:0] pixel;
  logic [2:0]  pixel_idx;
  logic        pixel_valid;
  logic        frame_done;
  logic        err;

  modport master (output din, input pixel, pixel_idx, pixel_valid, frame_done, err);
  modport slave  (input din, output pixel, pixel_idx, pixel_valid, frame_done, err);
endinterface

// File: rtl/ws2812_rx_pulse_timer.sv
// pulse_timer: resettable saturating up-counter with a compare-reached flag.
//   clk, rst  : clock, synchronous active-high reset
//   i_clr     : force count to 0
//   i_load1   : force count to 1 (first cycle of a new interval)
//   i_inc     : count up, holding at SAT
//   o_cnt     : current count
//   o_reached : count >= CMP
module pulse_timer #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned SAT   = 63,
  parameter int unsigned CMP   = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load1,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_reached
);
  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_load1) begin
      r_cnt <= WIDTH'(1);
    end else if (i_inc && (r_cnt != WIDTH'(SAT))) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt     = r_cnt;
  assign o_reached = (r_cnt >= WIDTH'(CMP));
endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire LED data decoder.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of ws2812_rx_if (din in; pixel, pixel_idx,
//              pixel_valid, frame_done, err out)
// High pulses 3..12 cycles decode as 0, 13..30 as 1; a low period of
// LATCH_CYC cycles ends the frame. Violations go through RECOVER, which
// waits for a full latch period of quiet line before accepting bits.
module ws2812_rx #(
  parameter int unsigned NUM_PIX   = 6,
  parameter int unsigned LATCH_CYC = ws2812_pkg::LATCH_CYC_DEF
) (
  input logic        clk,
  input logic        rst,
  ws2812_rx_if.slave bus
);
  import ws2812_pkg::*;

  localparam int unsigned LW  = $clog2(LATCH_CYC + 1);
  localparam int unsigned PCW = $clog2(NUM_PIX + 1);

  logic            r_sync, r_ds, r_ds_q;
  ws_state_e       r_state, w_state_nxt;
  logic [23:0]     r_shift, r_pixel;
  logic [4:0]      r_bitcnt;
  logic [PCW-1:0]  r_pixcnt;
  logic            r_ovf;
  logic [2:0]      r_idx;
  logic            r_pv, r_fd, r_err;

  logic [WCNT_W-1:0] w_wcnt;
  logic [LW-1:0]     w_lcnt;
  logic w_w_reach, w_l_reach;
  logic w_w_load1, w_w_inc, w_l_clr, w_l_load1, w_l_inc;
  logic w_bit_ok, w_bit_val, w_err_nxt, w_fd_nxt, w_clr_all, w_ovf_first;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 1'b0;
      r_ds   <= 1'b0;
      r_ds_q <= 1'b0;
    end else begin
      r_sync <= bus.din;
      r_ds   <= r_sync;
      r_ds_q <= r_ds;
    end
  end

  pulse_timer #(.WIDTH(WCNT_W), .SAT(WID_SAT), .CMP(WID_MAX + 1)) u_width (
    .clk(clk), .rst(rst), .i_clr(1'b0), .i_load1(w_w_load1), .i_inc(w_w_inc),
    .o_cnt(w_wcnt), .o_reached(w_w_reach)
  );

  pulse_timer #(.WIDTH(LW), .SAT(LATCH_CYC), .CMP(LATCH_CYC)) u_low (
    .clk(clk), .rst(rst), .i_clr(w_l_clr), .i_load1(w_l_load1), .i_inc(w_l_inc),
    .o_cnt(w_lcnt), .o_reached(w_l_reach)
  );

  // First bit beyond NUM_PIX pixels in this frame: flagged once.
  assign w_ovf_first = (r_bitcnt == 5'd0) && (r_pixcnt == PCW'(NUM_PIX)) && !r_ovf;

  always_comb begin
    w_state_nxt = r_state;
    w_w_load1   = 1'b0;
    w_w_inc     = 1'b0;
    w_l_clr     = 1'b0;
    w_l_load1   = 1'b0;
    w_l_inc     = 1'b0;
    w_bit_ok    = 1'b0;
    w_bit_val   = 1'b0;
    w_err_nxt   = 1'b0;
    w_fd_nxt    = 1'b0;
    w_clr_all   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_ds) begin
          w_state_nxt = HIGH;
          w_w_load1   = 1'b1;
        end
      end
      HIGH: begin
        // Overlong pulse is rejected while still high.
        if (w_w_reach) begin
          w_err_nxt   = 1'b1;
          w_l_clr     = 1'b1;
          w_state_nxt = RECOVER;
        end else if (!r_ds && r_ds_q) begin
          if (w_wcnt < WCNT_W'(WID_MIN)) begin
            w_err_nxt   = 1'b1;
            w_l_clr     = 1'b1;
            w_state_nxt = RECOVER;
          end else begin
            w_bit_ok    = 1'b1;
            w_bit_val   = (w_wcnt >= WCNT_W'(WID_ONE));
            w_err_nxt   = w_ovf_first;
            w_l_load1   = 1'b1;
            w_state_nxt = LOW;
          end
        end else if (r_ds) begin
          w_w_inc = 1'b1;
        end
      end
      LOW: begin
        if (r_ds) begin
          w_w_load1   = 1'b1;
          w_state_nxt = HIGH;
        end else if (w_lcnt == LW'(LATCH_CYC)) begin
          // A latch with a partial pixel pending is an error, not a frame end.
          w_fd_nxt    = (r_bitcnt == 5'd0);
          w_err_nxt   = (r_bitcnt != 5'd0);
          w_clr_all   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_l_inc = 1'b1;
        end
      end
      RECOVER: begin
        if (r_ds) begin
          w_l_clr = 1'b1;
        end else if (w_l_reach) begin
          w_clr_all   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_l_inc = 1'b1;
        end
      end
      default: w_state_nxt = RECOVER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RECOVER;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_pixcnt <= '0;
      r_ovf    <= 1'b0;
      r_pixel  <= '0;
      r_idx    <= '0;
      r_pv     <= 1'b0;
      r_fd     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_pv  <= 1'b0;
      r_fd  <= w_fd_nxt;
      r_err <= w_err_nxt;
      if (w_clr_all) begin
        r_shift  <= '0;
        r_bitcnt <= '0;
        r_pixcnt <= '0;
        r_ovf    <= 1'b0;
      end else if (w_bit_ok) begin
        r_shift <= {r_shift[22:0], w_bit_val};
        if (w_ovf_first) begin
          r_ovf <= 1'b1;
        end
        if (r_bitcnt == 5'd23) begin
          r_bitcnt <= '0;
          if (r_pixcnt < PCW'(NUM_PIX)) begin
            r_pixel  <= {r_shift[22:0], w_bit_val};
            r_idx    <= 3'(r_pixcnt);
            r_pv     <= 1'b1;
            r_pixcnt <= r_pixcnt + PCW'(1);
          end
        end else begin
          r_bitcnt <= r_bitcnt + 5'd1;
        end
      end
    end
  end

  assign bus.pixel       = r_pixel;
  assign bus.pixel_idx   = r_idx;
  assign bus.pixel_valid = r_pv;
  assign bus.frame_done  = r_fd;
  assign bus.err         = r_err;
endmodule
